ipml_fifo_pix_unpack: RTL and testbench

//   Read-side consumer of the AXI output prefetch FIFO, in the rd_clk (pixel) domain.

---
 rtl/ipml_fifo_pix_unpack.sv | 144 ++++++++++++++
 tb/tb_ipml_fifo_pix_unpack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ipml_fifo_pix_unpack.sv
// rtl/ipml_fifo_pix_unpack.sv - read-side FIFO word to pixel unpacker with underflow realignment
module ipml_fifo_pix_unpack #(
    parameter int c_IN_WIDTH  = 32,
    parameter int c_PIX_WIDTH = 16,
    parameter int c_LINE_PIX  = 1280,
    parameter int c_LSB_FIRST = 1,
    localparam int CNT_W      = (c_LINE_PIX > 1) ? $clog2(c_LINE_PIX) : 1
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   frame_sync,
    input  logic [c_IN_WIDTH-1:0]  fifo_data,
    input  logic                   fifo_vld,
    output logic                   fifo_en,
    input  logic                   pix_req,
    output logic [c_PIX_WIDTH-1:0] pix_data,
    output logic                   pix_vld,
    output logic                   line_end,
    output logic [CNT_W-1:0]       pix_cnt,
    output logic                   underflow
);

    localparam int N      = c_IN_WIDTH / c_PIX_WIDTH;
    localparam int SEL_W  = (N > 1) ? $clog2(N) : 1;
    localparam int MISS_W = $clog2(c_LINE_PIX + 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [c_IN_WIDTH-1:0]   word_buf;
    logic [SEL_W-1:0]        sel;
    logic                    buf_full;
    logic [MISS_W-1:0]       miss_cnt;

    logic                    run;
    logic                    avail;
    logic                    owed;
    logic                    consume;
    logic                    last_slice;
    logic                    pop;
    logic                    hit;
    logic                    miss;
    logic                    discard_idle;
    logic [c_PIX_WIDTH-1:0]  slice;
    int                      slice_idx;

    // State register: frame_sync is the only way into RUN, and there is no way out
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: any frame_sync lands in (or restarts) RUN
    always_comb begin
        state_nxt = state;
        if (frame_sync) begin
            state_nxt = ST_RUN;
        end
    end

    // Decode of this cycle's action; a frame_sync cycle does nothing but flush
    always_comb begin
        run          = (state == ST_RUN) && !frame_sync;
        avail        = buf_full;
        owed         = (miss_cnt != '0);
        consume      = run && avail && (pix_req || owed);
        last_slice   = consume && (sel == SEL_W'(N - 1));
        fifo_en      = run && (!buf_full || last_slice);
        pop          = fifo_en && fifo_vld;
        hit          = run && pix_req && avail && !owed;
        miss         = run && pix_req && !avail;
        discard_idle = run && !pix_req && avail && owed;
        slice_idx    = (c_LSB_FIRST != 0) ? int'(sel) : (N - 1 - int'(sel));
        slice        = word_buf[slice_idx*c_PIX_WIDTH +: c_PIX_WIDTH];
    end

    // Buffer, miss bookkeeping and registered pixel outputs
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            word_buf  <= '0;
            sel       <= '0;
            buf_full  <= 1'b0;
            miss_cnt  <= '0;
            pix_data  <= '0;
            pix_vld   <= 1'b0;
            line_end  <= 1'b0;
            pix_cnt   <= '0;
            underflow <= 1'b0;
        end else if (frame_sync) begin
            sel       <= '0;
            buf_full  <= 1'b0;
            miss_cnt  <= '0;
            pix_data  <= '0;
            pix_vld   <= 1'b0;
            line_end  <= 1'b0;
            pix_cnt   <= '0;
            underflow <= 1'b0;
        end else begin
            // A pop refills in the same cycle the last slice leaves, so no bubble
            if (pop) begin
                word_buf <= fifo_data;
                sel      <= '0;
                buf_full <= 1'b1;
            end else if (consume) begin
                if (last_slice) begin
                    sel      <= '0;
                    buf_full <= 1'b0;
                end else begin
                    sel <= sel + SEL_W'(1);
                end
            end

            if (miss) begin
                underflow <= 1'b1;
                if (miss_cnt != MISS_W'(c_LINE_PIX)) begin
                    miss_cnt <= miss_cnt + MISS_W'(1);
                end
            end else if (discard_idle) begin
                miss_cnt <= miss_cnt - MISS_W'(1);
            end

            pix_vld  <= hit;
            pix_data <= hit ? slice : '0;

            // Line position tracks requests, hit or miss, so timing stays locked to the display
            if (run && pix_req) begin
                if (pix_cnt == CNT_W'(c_LINE_PIX - 1)) begin
                    pix_cnt  <= '0;
                    line_end <= 1'b1;
                end else begin
                    pix_cnt  <= pix_cnt + CNT_W'(1);
                    line_end <= 1'b0;
                end
            end else begin
                line_end <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ipml_fifo_pix_unpack.sv
// tb/tb_ipml_fifo_pix_unpack.sv - directed self-checking bench for ipml_fifo_pix_unpack
module tb_ipml_fifo_pix_unpack;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        frame_sync = 1'b0;
    logic [31:0] fifo_data;
    logic        fifo_vld;
    logic        fifo_en;
    logic        pix_req = 1'b0;
    logic [15:0] pix_data;
    logic        pix_vld;
    logic        line_end;
    logic [2:0]  pix_cnt;
    logic        underflow;

    logic [31:0] fmem [0:15];
    int          wp = 0;
    int          rp = 0;
    int          checks = 0;
    int          failures = 0;

    ipml_fifo_pix_unpack #(
        .c_IN_WIDTH (32),
        .c_PIX_WIDTH(16),
        .c_LINE_PIX (8),
        .c_LSB_FIRST(1)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .frame_sync(frame_sync),
        .fifo_data (fifo_data),
        .fifo_vld  (fifo_vld),
        .fifo_en   (fifo_en),
        .pix_req   (pix_req),
        .pix_data  (pix_data),
        .pix_vld   (pix_vld),
        .line_end  (line_end),
        .pix_cnt   (pix_cnt),
        .underflow (underflow)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_vld  = (wp != rp);
    assign fifo_data = fmem[rp % 16];

    always @(posedge rd_clk) begin
        if (!rd_rst && fifo_vld && fifo_en) begin
            rp <= rp + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wp % 16] = w;
        wp = wp + 1;
    endtask

    initial begin
        // 1: reset values and IDLE behaviour
        tick();
        check("rst_pix_vld", pix_vld, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_line_end", line_end, 0);
        check("rst_underflow", underflow, 0);
        rd_rst = 1'b0;
        pix_req = 1'b1;
        #1;
        check("idle_fifo_en", fifo_en, 0);
        for (int i = 0; i < 3; i++) tick();
        check("idle_pix_vld", pix_vld, 0);
        check("idle_pix_cnt", pix_cnt, 0);
        check("idle_underflow", underflow, 0);
        check("idle_miss_cnt", dut.miss_cnt, 0);

        // 2: frame_sync with a same-cycle request, then four pixels from two words
        push(32'hBBBBAAAA);
        push(32'hDDDDCCCC);
        frame_sync = 1'b1;
        #1;
        check("fs_no_pop", fifo_en, 0);
        tick();
        frame_sync = 1'b0;
        pix_req = 1'b0;
        check("fs_pix_vld", pix_vld, 0);
        check("fs_pix_cnt", pix_cnt, 0);
        #1;
        check("run_fifo_en", fifo_en, 1);
        tick();
        pix_req = 1'b1;
        tick();
        check("px_aaaa", pix_data, 16'hAAAA);
        check("px_aaaa_vld", pix_vld, 1);
        tick();
        check("px_bbbb", pix_data, 16'hBBBB);
        check("pop_count_2", rp, 2);
        tick();
        check("px_cccc", pix_data, 16'hCCCC);
        tick();
        check("px_dddd", pix_data, 16'hDDDD);
        check("px_cnt_4", pix_cnt, 4);

        // 3: three misses, then realignment by discarding P0..P2
        for (int i = 0; i < 3; i++) begin
            tick();
            check("miss_vld", pix_vld, 0);
        end
        check("miss_underflow", underflow, 1);
        check("miss_cnt_3", dut.miss_cnt, 3);
        check("miss_pix_cnt", pix_cnt, 7);
        pix_req = 1'b0;
        push(32'h01010100);
        push(32'h01030102);
        for (int i = 0; i < 5; i++) tick();
        check("realign_miss_cnt", dut.miss_cnt, 0);
        check("realign_vld", pix_vld, 0);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        check("realign_p3", pix_data, 16'h0103);
        check("realign_p3_vld", pix_vld, 1);
        check("wrap_line_end", line_end, 1);
        check("wrap_pix_cnt", pix_cnt, 0);

        // 4: eight hits form a full line
        push(32'h00020001);
        push(32'h00040003);
        push(32'h00060005);
        push(32'h00080007);
        tick();
        check("idle_line_end", line_end, 0);
        pix_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("line_px", pix_data, k + 1);
            check("line_end", line_end, (k == 7) ? 1 : 0);
        end
        pix_req = 1'b0;
        check("line_cnt_0", pix_cnt, 0);
        check("line_underflow_sticky", underflow, 1);

        // 5: frame_sync drops the pending high half
        push(32'hBBBBAAAA);
        push(32'h22221111);
        tick();
        pix_req = 1'b1;
        tick();
        check("fs5_aaaa", pix_data, 16'hAAAA);
        pix_req = 1'b0;
        frame_sync = 1'b1;
        #1;
        check("fs5_no_pop", fifo_en, 0);
        tick();
        frame_sync = 1'b0;
        check("fs5_underflow", underflow, 0);
        check("fs5_buf_empty", dut.buf_full, 0);
        tick();
        pix_req = 1'b1;
        tick();
        check("fs5_1111", pix_data, 16'h1111);
        check("fs5_pix_cnt", pix_cnt, 1);
        tick();
        check("fs5_2222", pix_data, 16'h2222);
        check("fs5_pix_cnt2", pix_cnt, 2);

        // 6: asynchronous reset mid-line
        #1;
        rd_rst = 1'b1;
        #1;
        check("arst_pix_vld", pix_vld, 0);
        check("arst_pix_data", pix_data, 0);
        check("arst_pix_cnt", pix_cnt, 0);
        check("arst_fifo_en", fifo_en, 0);
        tick();
        rd_rst = 1'b0;
        push(32'h66665555);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_idle_vld", pix_vld, 0);
            check("arst_idle_en", fifo_en, 0);
            check("arst_idle_cnt", pix_cnt, 0);
        end
        pix_req = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        check("arst_restart_px", pix_data, 16'h5555);
        check("arst_restart_vld", pix_vld, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
